cog_knob: RTL and testbench

- Front end that drives the step interface of the cog block from a physical rotary quadrature encoder with a push switch.
- Synchronises and debounces the raw encoder A/B and switch inputs, then decodes the quadrature phase.
- Emits one single-cycle cnt pulse per valid quadrature edge, with a stable dir level; one detent is 4 edges, which the cog block divides by 4 internally.
- Switch presses toggle mode; the switch is active-low.

---
 rtl/cog_knob.sv | 253 +++++++++++++++++++++++++
 tb/tb_cog_knob.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cog_knob.sv
// -----------------------------------------------------------------------------
// cog_knob
//
// Rotary quadrature encoder front end for the cog block step interface.
// The raw encoder phases and the push switch are synchronised and debounced.
// Each debounced quadrature edge becomes one single-cycle step pulse with a
// direction level. Each accepted switch press toggles a mode flag.
//
// Ports
//   clk     in   system clock, all logic on posedge
//   rst_n   in   asynchronous active-low reset
//   enc_a   in   raw encoder phase A (asynchronous)
//   enc_b   in   raw encoder phase B (asynchronous)
//   enc_sw  in   raw push switch, active-low (asynchronous)
//   cnt     out  single-cycle step pulse, one per valid quadrature edge
//   dir     out  direction of the latest step, 1 = CW (A leads B), 0 = CCW
//   mode    out  mode flag, toggled by each accepted switch press
//   err     out  single-cycle pulse on an illegal (double-bit) transition
//   ready   out  high once the input baseline has been captured
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_INIT | waiting for {A,B,SW} to sit still for DEB_CYCLES clocks, then
//           | the debounced registers are loaded from it as the baseline
//   ST_RUN  | normal operation: per-input debounce, quadrature decode, switch
// -----------------------------------------------------------------------------
module cog_knob #(
    parameter int DEB_CYCLES    = 1000,
    parameter int SW_DEB_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enc_sw,
    output logic cnt,
    output logic dir,
    output logic mode,
    output logic err,
    output logic ready
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counters compare against threshold-1: the threshold is reached on the
    // same cycle the counter would have stepped onto it.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_DEB_LAST = CNT_W'(SW_DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t state;
    state_t state_nxt;

    // Synchronisers, bit order {A, B, SW}
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [1:0] s_ab;
    logic       s_sw;

    // Baseline capture
    logic [2:0]       prev_s;
    logic [CNT_W-1:0] stable_cnt;
    logic             init_done;

    // Debounced levels, bit order {A, B}
    logic [1:0]       deb_ab;
    logic             deb_sw;
    logic [CNT_W-1:0] deb_cnt_ab [2];
    logic [CNT_W-1:0] deb_cnt_sw;

    // Previous-cycle copies used by the registered decode
    logic [1:0] deb_ab_q;
    logic       deb_sw_q;

    // Decode
    logic [1:0] pos_old;
    logic [1:0] pos_new;
    logic [1:0] pos_delta;
    logic       step_cw;
    logic       step_ccw;
    logic       step_err;
    logic       press;

    assign s_ab = sync2[2:1];
    assign s_sw = sync2[0];

    // -------------------------------------------------------------------------
    // Two-flop synchronisers; stage 1 is only ever read by stage 2.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= {enc_a, enc_b, enc_sw};
            sync2 <= sync1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init_done = 1'b0;
        ready     = 1'b0;
        case (state)
            ST_INIT: begin
                if ((sync2 == prev_s) && (stable_cnt == DEB_LAST)) begin
                    init_done = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Baseline capture: all three inputs must be jointly quiet for
    // DEB_CYCLES clocks before their levels are trusted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_s     <= 3'b111;
            stable_cnt <= '0;
        end else if (state == ST_INIT) begin
            prev_s <= sync2;
            if (sync2 != prev_s) begin
                stable_cnt <= '0;
            end else if (init_done) begin
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-input debounce. The baseline load also primes the previous-cycle
    // copies so the first RUN cycle does not see a fake transition.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_ab     <= 2'b11;
            deb_sw     <= 1'b1;
            deb_ab_q   <= 2'b11;
            deb_sw_q   <= 1'b1;
            deb_cnt_sw <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_ab[i] <= '0;
            end
        end else if (state == ST_INIT) begin
            if (init_done) begin
                deb_ab   <= s_ab;
                deb_sw   <= s_sw;
                deb_ab_q <= s_ab;
                deb_sw_q <= s_sw;
            end
        end else begin
            deb_ab_q <= deb_ab;
            deb_sw_q <= deb_sw;

            for (int i = 0; i < 2; i++) begin
                if (s_ab[i] == deb_ab[i]) begin
                    deb_cnt_ab[i] <= '0;
                end else if (deb_cnt_ab[i] == DEB_LAST) begin
                    deb_ab[i]     <= s_ab[i];
                    deb_cnt_ab[i] <= '0;
                end else begin
                    deb_cnt_ab[i] <= deb_cnt_ab[i] + CNT_ONE;
                end
            end

            if (s_sw == deb_sw) begin
                deb_cnt_sw <= '0;
            end else if (deb_cnt_sw == SW_DEB_LAST) begin
                deb_sw     <= s_sw;
                deb_cnt_sw <= '0;
            end else begin
                deb_cnt_sw <= deb_cnt_sw + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Quadrature decode. {A,B} is mapped to its position on the Gray cycle
    // 00 -> 10 -> 11 -> 01 (CW order); the wrapped position difference then
    // says +1 = CW, -1 = CCW, 2 = both bits flipped (illegal), 0 = no move.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] p;
        case (ab)
            2'b00:   p = 2'd0;
            2'b10:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    always_comb begin
        pos_old   = gray_pos(deb_ab_q);
        pos_new   = gray_pos(deb_ab);
        pos_delta = pos_new - pos_old;
        step_cw   = 1'b0;
        step_ccw  = 1'b0;
        step_err  = 1'b0;
        press     = 1'b0;
        if (state == ST_RUN) begin
            step_cw  = (pos_delta == 2'd1);
            step_ccw = (pos_delta == 2'd3);
            step_err = (pos_delta == 2'd2);
            press    = deb_sw_q & ~deb_sw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 1'b0;
            err  <= 1'b0;
            dir  <= 1'b0;
            mode <= 1'b0;
        end else begin
            cnt <= step_cw | step_ccw;
            err <= step_err;
            if (step_cw | step_ccw) begin
                dir <= step_cw;
            end
            if (press) begin
                mode <= ~mode;
            end
        end
    end

endmodule

// File: tb/tb_cog_knob.sv
module tb_cog_knob;

    localparam int DEB = 4;
    localparam int SW  = 12;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enc_a  = 1'b0;
    logic enc_b  = 1'b0;
    logic enc_sw = 1'b1;
    logic cnt, dir, mode, err, ready;

    cog_knob #(
        .DEB_CYCLES    (DEB),
        .SW_DEB_CYCLES (SW),
        .CNT_W         (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .enc_sw (enc_sw),
        .cnt    (cnt),
        .dir    (dir),
        .mode   (mode),
        .err    (err),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int t;
        bit c;
        bit e;
        bit d;
        bit tog;
    } ev_t;

    ev_t sb[$];

    // Model state: accepted {A,B} level; position on the CW Gray cycle
    logic [1:0] m_ab;
    int pos_of [4];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0b exp=%0b cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input ev_t ev);
        int i;
        i = 0;
        while (i < sb.size() && sb[i].t <= ev.t) i++;
        sb.insert(i, ev);
    endtask

    // Drive {A,B}=v for h clocks. A hold of at least DEB is accepted and
    // produces a step/err at (drive cycle + DEB + 3); a shorter one is a
    // glitch that is withdrawn and must leave no trace.
    task automatic drive_ab(input logic [1:0] v, input int h);
        ev_t ev;
        int d;
        enc_a = v[1];
        enc_b = v[0];
        if (h >= DEB && v != m_ab) begin
            d      = (pos_of[v] - pos_of[m_ab] + 4) % 4;
            ev.t   = cyc + DEB + 3;
            ev.c   = (d != 2);
            ev.e   = (d == 2);
            ev.d   = (d == 1);
            ev.tog = 1'b0;
            push_ev(ev);
        end
        if (h >= DEB) m_ab = v;
        repeat (h) @(posedge clk);
        #1;
        if (h < DEB) begin
            enc_a = m_ab[1];
            enc_b = m_ab[0];
            repeat (DEB + 2) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_tog(input int t);
        ev_t ev;
        ev.t = t; ev.c = 1'b0; ev.e = 1'b0; ev.d = 1'b0; ev.tog = 1'b1;
        push_ev(ev);
    endtask

    // Hold the switch low for h clocks, then release and let it settle.
    task automatic press(input int h);
        enc_sw = 1'b0;
        if (h >= SW) push_tog(cyc + SW + 3);
        repeat (h) @(posedge clk);
        #1;
        enc_sw = 1'b1;
        repeat (SW + 4) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    // Monitor: pops whatever the model expects for this cycle and compares
    // it with what the DUT presents.
    bit x_dir  = 1'b0;
    bit x_mode = 1'b0;
    always @(negedge clk) begin : monitor
        ev_t ev;
        bit ec, ee, et;
        if (!rst_n) begin
            sb.delete();
            x_dir  = 1'b0;
            x_mode = 1'b0;
        end else begin
            ec = 1'b0; ee = 1'b0; et = 1'b0;
            while (sb.size() > 0 && sb[0].t <= cyc) begin
                ev = sb.pop_front();
                if (ev.t < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missed_event due=%0d now=%0d", ev.t, cyc);
                end else begin
                    ec |= ev.c;
                    ee |= ev.e;
                    if (ev.c) x_dir = ev.d;
                    if (ev.tog) et = 1'b1;
                end
            end
            if (et) x_mode = ~x_mode;
            chk("cnt", cnt, ec);
            chk("err", err, ee);
            chk("dir", dir, x_dir);
            chk("mode", mode, x_mode);
            chk("cnt_err_excl", cnt & err, 1'b0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        logic [1:0] v;
        pos_of[0] = 0;  // 00
        pos_of[2] = 1;  // 10
        pos_of[3] = 2;  // 11
        pos_of[1] = 3;  // 01
        m_ab = 2'b00;

        // 1: reset, baseline 00 / switch released
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b0);
        chk("rst_mode", mode, 1'b0);
        rst_n = 1'b1;
        wait_ready(n);
        chk_int("ready_latency", n, DEB + 3);
        chk("init_mode", mode, 1'b0);

        // 2: full CW detent then full CCW detent
        drive_ab(2'b10, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b01, 10);
        drive_ab(2'b00, 10);
        drive_ab(2'b01, 10);
        drive_ab(2'b11, 10);
        drive_ab(2'b10, 10);
        drive_ab(2'b00, 10);

        // 3: A glitch shorter than the threshold, then a real step proves 00 held
        drive_ab(2'b10, 3);
        drive_ab(2'b10, 10);
        drive_ab(2'b00, 10);

        // 4: double-bit jump, then a legal step from the new reference
        drive_ab(2'b11, 10);
        drive_ab(2'b01, 10);
        drive_ab(2'b00, 10);

        // 5: two accepted presses and a 1-clock glitch
        press(SW + 5);
        press(SW + 5);
        press(1);

        // switch press and step landing on the same cycle
        enc_sw = 1'b0;
        push_tog(cyc + SW + 3);
        repeat (SW - DEB) @(posedge clk);
        #1;
        drive_ab(2'b10, DEB + 6);
        enc_sw = 1'b1;
        repeat (SW + 4) @(posedge clk);
        #1;

        // randomized steps, glitches and presses
        for (int k = 0; k < 40; k++) begin
            v = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                drive_ab(v, $urandom_range(1, DEB - 1));
            else
                drive_ab(v, $urandom_range(DEB, DEB + 5));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) press($urandom_range(1, SW - 1));
                else press($urandom_range(SW + 1, SW + 6));
            end
        end
        repeat (20) @(posedge clk);
        #1;

        // 6: reset in the middle of a debounce with mode=1
        drive_ab(2'b00, DEB + 6);
        if (mode == 1'b0) press(SW + 5);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_mode", mode, 1'b1);
        enc_a = 1'b1;
        enc_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_mode", mode, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_cnt", cnt, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        m_ab  = 2'b10;
        rst_n = 1'b1;
        wait_ready(n);
        chk_int("ready_latency_2", n, DEB + 3);
        drive_ab(2'b11, 10);
        drive_ab(2'b10, 10);

        repeat (30) @(posedge clk);
        #1;
        t0 = sb.size();
        chk_int("sb_drained", t0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
